// File: rtl/bus_interconnect.sv
// Single-master, N-slave bus interconnect: base/mask address decode with fixed priority,
// a registered IDLE/ACTIVE/RESP transaction engine, wait states, timeout and sticky error capture.
module bus_interconnect #(
    parameter int                          NSLAVES    = 4,
    parameter int                          ADDR_W     = 16,
    parameter int                          DATA_W     = 8,
    parameter logic [NSLAVES*ADDR_W-1:0]   SLAVE_BASE = '0,
    parameter logic [NSLAVES*ADDR_W-1:0]   SLAVE_MASK = '0,
    parameter int                          TIMEOUT    = 15
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic [ADDR_W-1:0]           i_m_addr,
    input  logic [DATA_W-1:0]           i_m_dat,
    output logic [DATA_W-1:0]           o_m_dat,
    input  logic                        i_m_cs,
    input  logic                        i_m_we,
    output logic                        o_m_ack,
    output logic                        o_m_err,
    output logic [ADDR_W-1:0]           o_s_addr,
    output logic [DATA_W-1:0]           o_s_dat,
    output logic                        o_s_we,
    output logic [NSLAVES-1:0]          o_s_cs,
    input  logic [NSLAVES*DATA_W-1:0]   i_s_dat,
    input  logic [NSLAVES-1:0]          i_s_ack,
    output logic                        o_err_flag,
    output logic [ADDR_W-1:0]           o_err_addr,
    input  logic                        i_err_clr,
    output logic [1:0]                  o_dbg_state
);

    // Handshake: i_m_cs is held by the master until o_m_ack pulses for one cycle;
    // a slave completes by raising i_s_ack while its o_s_cs bit is high.

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                 state, next_state;
    logic [CNT_W-1:0]       cnt;

    logic [NSLAVES-1:0]     match_oh;
    logic                   match_any;
    logic                   sel_ack;
    logic [DATA_W-1:0]      sel_dat;

    logic                   start_txn;
    logic                   resp_ok;
    logic                   resp_err_to;
    logic                   resp_err_um;
    logic                   ack_d;
    logic                   err_d;
    logic [NSLAVES-1:0]     cs_d;

    // Fixed-priority decode: the first (lowest-index) matching region wins.
    always_comb begin
        match_oh  = '0;
        match_any = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (!match_any &&
                ((i_m_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                 (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W]))) begin
                match_oh[i] = 1'b1;
                match_any   = 1'b1;
            end
        end
    end

    // The registered one-hot select gates ack and data, so unselected slaves are ignored.
    always_comb begin
        sel_ack = |(i_s_ack & o_s_cs);
        sel_dat = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (o_s_cs[i]) begin
                sel_dat = sel_dat | i_s_dat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_m_cs) begin
                    next_state = match_any ? ST_ACTIVE : ST_RESP;
                end
            end
            ST_ACTIVE: begin
                if (!i_m_cs) begin
                    next_state = ST_IDLE;
                end else if (sel_ack || (cnt == CNT_LAST)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Master abort takes precedence; ack beats a coincident timeout.
    always_comb begin
        start_txn   = (state == ST_IDLE) && i_m_cs && match_any;
        resp_err_um = (state == ST_IDLE) && i_m_cs && !match_any;
        resp_ok     = (state == ST_ACTIVE) && i_m_cs && sel_ack;
        resp_err_to = (state == ST_ACTIVE) && i_m_cs && !sel_ack && (cnt == CNT_LAST);
        ack_d       = resp_ok || resp_err_to || resp_err_um;
        err_d       = resp_err_to || resp_err_um;
        cs_d        = '0;
        if (start_txn) begin
            cs_d = match_oh;
        end else if ((state == ST_ACTIVE) && (next_state == ST_ACTIVE)) begin
            cs_d = o_s_cs;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt        <= '0;
            o_m_ack    <= 1'b0;
            o_m_err    <= 1'b0;
            o_m_dat    <= '0;
            o_s_cs     <= '0;
            o_s_we     <= 1'b0;
            o_s_addr   <= '0;
            o_s_dat    <= '0;
            o_err_flag <= 1'b0;
            o_err_addr <= '0;
        end else begin
            o_m_ack <= ack_d;
            o_m_err <= err_d;
            o_s_cs  <= cs_d;

            if (start_txn) begin
                cnt      <= '0;
                o_s_addr <= i_m_addr;
                o_s_dat  <= i_m_dat;
                o_s_we   <= i_m_we;
            end else if ((state == ST_ACTIVE) && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end

            if (resp_ok) begin
                o_m_dat <= sel_dat;
            end else if (err_d) begin
                o_m_dat <= '1;
            end

            if (err_d) begin
                o_err_flag <= 1'b1;
            end else if (i_err_clr) begin
                o_err_flag <= 1'b0;
            end

            if (resp_err_um) begin
                o_err_addr <= i_m_addr;
            end else if (resp_err_to) begin
                o_err_addr <= o_s_addr;
            end
        end
    end

    assign o_dbg_state = state;

endmodule

// File: doc/bus_interconnect.md
# bus_interconnect

Parametrised single-master, N-slave bus interconnect for the 8-bit CPU bus. It replaces hand-written address-decode and data/ack multiplexing in the system top with a registered transaction engine. The engine provides:
- programmable base/mask regions, resolved by fixed priority;
- latched slave select for the whole transaction;
- wait-state support through per-slave ack;
- a bus-timeout and unmapped-address error path with a sticky error-address register.

## Interface
Parameters:
- NSLAVES, 4, number of slave ports (1..16)
- ADDR_W, 16, address width
- DATA_W, 8, data width
- SLAVE_BASE, 0, packed NSLAVES*ADDR_W; slave i base at bits [i*ADDR_W +: ADDR_W]
- SLAVE_MASK, 0, packed NSLAVES*ADDR_W; slave i mask, same packing
- TIMEOUT, 15, ACTIVE cycles without ack before error (1..255)

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  reset, asynchronous, active-low
- i_m_addr  in  ADDR_W  master address
- i_m_dat  in  DATA_W  master write data
- o_m_dat  out  DATA_W  read data to master, valid while o_m_ack=1
- i_m_cs  in  1  master request, held until ack
- i_m_we  in  1  1=write, 0=read
- o_m_ack  out  1  one-cycle transaction-complete pulse
- o_m_err  out  1  qualifies o_m_ack: transaction failed
- o_s_addr  out  ADDR_W  latched address to all slaves
- o_s_dat  out  DATA_W  latched write data to all slaves
- o_s_we  out  1  latched write enable
- o_s_cs  out  NSLAVES  one-hot slave select, registered
- i_s_dat  in  NSLAVES*DATA_W  slave read data, slave i at [i*DATA_W +: DATA_W]
- i_s_ack  in  NSLAVES  slave ack, sampled only for the selected slave
- o_err_flag  out  1  sticky error indicator
- o_err_addr  out  ADDR_W  address of the most recent failed transaction
- i_err_clr  in  1  clears o_err_flag (o_err_addr retained)

## Operation
- Match rule: slave i matches when (i_m_addr & MASK_i) == (BASE_i & MASK_i).
  - Lowest matching index wins.
  - MASK=0 makes a catch-all region; place it at the highest index.
- FSM states: IDLE, ACTIVE, RESP.
- IDLE, i_m_cs=1, match found:
  - latch addr, dat, we and the one-hot select;
  - clear the timeout counter;
  - go to ACTIVE.
- IDLE, i_m_cs=1, no match: go to RESP with error, unmapped. No slave select is asserted.
- ACTIVE:
  - o_s_cs[sel]=1; all other select bits 0.
  - i_s_ack[sel]=1: capture i_s_dat[sel] into the data register, go to RESP with no error.
  - No ack: increment the counter. When the counter reaches TIMEOUT-1 without ack, go to RESP with error.
  - i_m_cs=0 (master abort): go to IDLE, no ack, no error logged.
- RESP:
  - o_m_ack=1 for exactly one cycle; o_s_cs all 0.
  - Then go to IDLE.
  - IDLE ignores i_m_cs in the cycle where o_m_ack=1, because that cycle is RESP.
- Error response:
  - o_m_err=1 and o_m_dat = all ones.
  - o_err_flag is set and o_err_addr is loaded with the offending address.
  - A write with error has no side effects.
- o_m_dat outside the ack cycle holds its last value; masters must not rely on it.
- Simultaneous events:
  - ack and timeout in the same cycle: ack wins, no error.
  - i_err_clr together with a new error: the set wins.
- i_s_ack from unselected slaves is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - o_m_ack=0, o_m_err=0, o_m_dat=0;
  - o_s_cs=0, o_s_we=0, o_s_addr=0, o_s_dat=0;
  - o_err_flag=0, o_err_addr=0;
  - FSM=IDLE, counter=0.
- Reset asserted mid-transaction: immediate return to reset state. The pending transaction is dropped silently.
- Zero-wait slave (ack combinational on o_s_cs):
  - request sampled at edge 0;
  - o_s_cs high during cycle 1;
  - o_m_ack high during cycle 2.
  - Minimum latency is 2 cycles from request to ack; throughput is 1 transaction per 3 cycles.
- Each wait state adds 1 cycle.
- Timeout: o_m_ack with o_m_err is high in cycle TIMEOUT+1 after the request edge.
- Unmapped address: o_m_ack with o_m_err is high in cycle 1.
- o_s_addr, o_s_dat and o_s_we are stable for the whole ACTIVE phase, independent of master changes.
- The timeout counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

## Test plan
Bench configuration: NSLAVES=3.
- Slave 0: base 0xfa00, mask 0xfff0 (uart).
- Slave 1: base 0xfa10, mask 0xfff0 (vga).
- Slave 2: base 0x0000, mask 0x0000 (memory).

Directed scenarios:
- Read 0xfa01, slave 0 zero-wait, returning 0x5a -> o_s_cs=3'b001 in cycle 1; o_m_ack=1, o_m_dat=0x5a, o_m_err=0 in cycle 2.
- Write 0x1234 with data 0xa5, slave 2 acking after 3 waits -> o_s_cs=3'b100 with o_s_we=1, o_s_dat=0xa5 for 4 cycles; ack in cycle 5.
- Read 0xfa13 with slave 1 never acking, TIMEOUT=15 -> o_m_ack=1, o_m_err=1, o_m_dat=0xff in cycle 16; o_err_addr=0xfa13; o_err_flag=1 until i_err_clr.
- Build with slave 2 removed (NSLAVES=2), read 0x8000 -> error ack in cycle 1; o_s_cs never asserted.
- Master drops i_m_cs in cycle 2 of a waited access, then requests 0xfa10 -> no ack for the first access; the second completes normally.
- i_reset_n pulsed low during ACTIVE -> all outputs 0 asynchronously; the next request completes with normal latency.
